// File: rtl/ssid_pkg.sv
// Shared types and constants for the SSID address sequencer.
package ssid_pkg;

  localparam int SSIDBITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_LIST   = 1'b1;

endpackage

// File: rtl/ssid_list_table.sv
// SSID list table: register array, synchronous write, asynchronous read.
module ssid_list_table #(
  parameter int SSIDBITS   = 8,
  parameter int LIST_DEPTH = 32,
  localparam int LIST_AW   = $clog2(LIST_DEPTH)
) (
  input  logic                clock,
  input  logic                wrEn,
  input  logic [LIST_AW-1:0]  wrAddr,
  input  logic [SSIDBITS-1:0] wrData,
  input  logic [LIST_AW-1:0]  rdAddr,
  output logic [SSIDBITS-1:0] rdData
);

  // No reset: contents survive a sequencer reset.
  logic [SSIDBITS-1:0] mem [LIST_DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/ssid_address_sequencer.sv
// SSID address source for HNM/HCM lookups: linear sweep or list playback
// with a valid/ready handshake and optional looping.
module ssid_address_sequencer
  import ssid_pkg::*;
#(
  parameter int SSIDBITS   = SSIDBITS_DEF,
  parameter int LIST_DEPTH = 32,
  localparam int LIST_AW   = $clog2(LIST_DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic                loop,
  input  logic                stop,
  input  logic [SSIDBITS-1:0] lin_first,
  input  logic [SSIDBITS-1:0] lin_last,
  input  logic [LIST_AW:0]    list_len,
  input  logic                tbl_wr_en,
  input  logic [LIST_AW-1:0]  tbl_wr_addr,
  input  logic [SSIDBITS-1:0] tbl_wr_data,
  output logic [SSIDBITS-1:0] ssid,
  output logic                ssid_valid,
  input  logic                ssid_ready,
  output logic                busy,
  output logic                done,
  output logic [15:0]         emitted
);

  localparam logic [LIST_AW:0] DEPTH_W = (LIST_AW+1)'(LIST_DEPTH);

  state_t stateQ, stateNext;

  logic                modeQ, loopQ;
  logic [SSIDBITS-1:0] firstQ, lastQ, ssidQ, rdData;
  logic [LIST_AW:0]    lenQ, lenClamped;
  logic [LIST_AW-1:0]  idxQ, rdAddr;
  logic [15:0]         emittedQ;
  logic                accept, lastElem, emptyList;

  ssid_list_table #(
    .SSIDBITS   (SSIDBITS),
    .LIST_DEPTH (LIST_DEPTH)
  ) uTable (
    .clock  (clock),
    .wrEn   (tbl_wr_en),
    .wrAddr (tbl_wr_addr),
    .wrData (tbl_wr_data),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  always_comb begin
    lenClamped = (list_len > DEPTH_W) ? DEPTH_W : list_len;
    emptyList  = (mode == MODE_LIST) && (lenClamped == '0);
    accept     = ssid_valid && ssid_ready;
    if (modeQ == MODE_LIST) lastElem = ({1'b0, idxQ} == (lenQ - (LIST_AW+1)'(1)));
    else                    lastElem = (ssidQ == lastQ);
    // The read port always looks one entry ahead, so the registered ssid can
    // advance on every accept; it points at entry 0 when idle or on wrap.
    if ((stateQ == ST_RUN) && !lastElem) rdAddr = idxQ + LIST_AW'(1);
    else                                 rdAddr = '0;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) stateQ <= ST_IDLE;
    else       stateQ <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      ST_IDLE: if (start) stateNext = emptyList ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (stop)                              stateNext = ST_DONE;
        else if (accept && lastElem && !loopQ) stateNext = ST_DONE;
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ssid_valid = (stateQ == ST_RUN);
    busy       = (stateQ == ST_RUN);
    done       = (stateQ == ST_DONE);
    ssid       = ssidQ;
    emitted    = emittedQ;
  end

  // Configuration, index, SSID and emitted-count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      modeQ    <= MODE_LINEAR;
      loopQ    <= 1'b0;
      firstQ   <= '0;
      lastQ    <= '0;
      lenQ     <= '0;
      idxQ     <= '0;
      ssidQ    <= '0;
      emittedQ <= '0;
    end else begin
      if ((stateQ == ST_IDLE) && start) begin
        modeQ    <= mode;
        loopQ    <= loop;
        firstQ   <= lin_first;
        lastQ    <= lin_last;
        lenQ     <= lenClamped;
        idxQ     <= '0;
        emittedQ <= '0;
        ssidQ    <= (mode == MODE_LINEAR) ? lin_first : rdData;
      end else if ((stateQ == ST_RUN) && accept) begin
        if (emittedQ != '1) emittedQ <= emittedQ + 16'd1;
        if (lastElem) begin
          idxQ  <= '0;
          ssidQ <= (modeQ == MODE_LINEAR) ? firstQ : rdData;
        end else begin
          idxQ  <= idxQ + LIST_AW'(1);
          ssidQ <= (modeQ == MODE_LINEAR) ? ssidQ + SSIDBITS'(1) : rdData;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssid_address_sequencer.sv
// Self-checking bench for ssid_address_sequencer: vector table, directed
// corner sequences and randomized traffic against a pass-level model.
module tb_ssid_address_sequencer;

  localparam int SB    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clock = 1'b0;
  logic          reset, start, mode, loop, stop, tbl_wr_en, ssid_ready;
  logic [SB-1:0] lin_first, lin_last, tbl_wr_data, ssid;
  logic [AW:0]   list_len;
  logic [AW-1:0] tbl_wr_addr;
  logic          ssid_valid, busy, done;
  logic [15:0]   emitted;

  always #5 clock = ~clock;

  ssid_address_sequencer #(.SSIDBITS(SB), .LIST_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .loop        (loop),
    .stop        (stop),
    .lin_first   (lin_first),
    .lin_last    (lin_last),
    .list_len    (list_len),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .ssid        (ssid),
    .ssid_valid  (ssid_valid),
    .ssid_ready  (ssid_ready),
    .busy        (busy),
    .done        (done),
    .emitted     (emitted)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Pass-level reference: a pass is mLen items, item p = first+p or table[p].
  bit            mBusy, mDone, mMode, mLoop, mSsidChk;
  int            mPos, mLen, mEmit;
  logic [SB-1:0] mFirst, mCur;
  logic [SB-1:0] mTbl [DEPTH];

  function automatic logic [SB-1:0] item(input int p);
    if (mMode) return mTbl[p];
    return mFirst + SB'(p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic [SB-1:0] span;
    if (reset) begin
      mBusy = 0; mDone = 0; mEmit = 0; mCur = '0; mSsidChk = 1;
    end else if (mDone) begin
      mDone = 0; mSsidChk = 0;
    end else if (mBusy) begin
      if (ssid_ready && mEmit < 65535) mEmit++;
      if (stop) begin
        mBusy = 0; mDone = 1;
      end else if (ssid_ready) begin
        mPos++;
        if (mPos == mLen) begin
          if (mLoop) mPos = 0;
          else begin mBusy = 0; mDone = 1; end
        end
        if (mBusy) mCur = item(mPos);
      end
      mSsidChk = mBusy;
    end else if (start) begin
      mMode = mode; mLoop = loop; mFirst = lin_first; mEmit = 0; mPos = 0;
      span = lin_last - lin_first;
      if (mode) mLen = (int'(list_len) > DEPTH) ? DEPTH : int'(list_len);
      else      mLen = int'(span) + 1;
      if (mLen == 0) begin mDone = 1; mSsidChk = 0; end
      else begin mBusy = 1; mCur = item(0); mSsidChk = 1; end
    end else begin
      mSsidChk = 0;
    end
    if (tbl_wr_en) mTbl[tbl_wr_addr] = tbl_wr_data;
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    #1;
    check("valid", ssid_valid, mBusy);
    check("busy", busy, mBusy);
    check("done", done, mDone);
    check("emitted", emitted, mEmit);
    if (mSsidChk) check("ssid", ssid, mCur);
  endtask

  task automatic writeTbl(input int a, input logic [SB-1:0] d);
    tbl_wr_en = 1; tbl_wr_addr = AW'(a); tbl_wr_data = d;
    step();
    tbl_wr_en = 0;
  endtask

  task automatic startRun(input logic m, input logic lp, input logic [SB-1:0] f,
                          input logic [SB-1:0] l, input logic [AW:0] len);
    mode = m; loop = lp; lin_first = f; lin_last = l; list_len = len; start = 1;
    step();
    start = 0;
  endtask

  typedef struct {
    logic          m;
    logic [SB-1:0] f, l;
    logic [AW:0]   len;
    int            expN;
    logic [SB-1:0] expFirst, expLast;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int            cnt, guard;
    logic [SB-1:0] fs, ls;
    logic [SB-1:0] loopExp [4];

    reset = 1; start = 0; mode = 0; loop = 0; stop = 0; tbl_wr_en = 0;
    tbl_wr_addr = '0; tbl_wr_data = '0; lin_first = '0; lin_last = '0;
    list_len = '0; ssid_ready = 0;
    step(); step();
    check("rstSsid", ssid, 0);
    check("rstValid", ssid_valid, 0);
    check("rstEmitted", emitted, 0);
    reset = 0;

    for (int i = 0; i < DEPTH; i++) writeTbl(i, SB'(i * 7 + 3));

    // {mode, first, last, len, count, first ssid, last ssid}
    vecs[0] = '{1'b0, 8'h10, 8'h13, 6'd0,  4,   8'h10, 8'h13};
    vecs[1] = '{1'b0, 8'hFE, 8'h01, 6'd0,  4,   8'hFE, 8'h01};
    vecs[2] = '{1'b0, 8'h55, 8'h55, 6'd0,  1,   8'h55, 8'h55};
    vecs[3] = '{1'b0, 8'h01, 8'h00, 6'd0,  256, 8'h01, 8'h00};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 6'd3,  3,   8'h03, 8'h11};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 6'd40, 32,  8'h03, 8'hDC};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 6'd0,  0,   8'h00, 8'h00};

    for (int v = 0; v < 7; v++) begin
      ssid_ready = 1;
      startRun(vecs[v].m, 1'b0, vecs[v].f, vecs[v].l, vecs[v].len);
      cnt = 0; guard = 0; fs = '0; ls = '0;
      while (!done && guard < 400) begin
        if (ssid_valid && ssid_ready) begin
          if (cnt == 0) fs = ssid;
          ls = ssid;
          cnt++;
        end
        step();
        guard++;
      end
      check("vecDone", done, 1);
      check("vecCount", cnt, vecs[v].expN);
      check("vecEmitted", emitted, vecs[v].expN);
      if (vecs[v].expN > 0) begin
        check("vecFirst", fs, vecs[v].expFirst);
        check("vecLast", ls, vecs[v].expLast);
      end
      step();
    end

    // Stall: list {03,7C,48}, ready 1,0,0,1,1
    writeTbl(0, 8'h03); writeTbl(1, 8'h7C); writeTbl(2, 8'h48);
    startRun(1'b1, 1'b0, '0, '0, 6'd3);
    ssid_ready = 1; step();
    ssid_ready = 0; step();
    check("stallHold1", ssid, 8'h7C);
    step();
    check("stallHold2", ssid, 8'h7C);
    ssid_ready = 1; step();
    check("stallNext", ssid, 8'h48);
    step();
    check("stallDone", done, 1);
    check("stallEmitted", emitted, 3);
    step();

    // Empty list: straight to done, no valid
    startRun(1'b1, 1'b0, '0, '0, 6'd0);
    check("emptyDone", done, 1);
    check("emptyValid", ssid_valid, 0);
    step();
    check("emptyIdle", done, 0);

    // Loop playback with stop on the second B2 accept
    writeTbl(0, 8'hA1); writeTbl(1, 8'hB2);
    loopExp[0] = 8'hA1; loopExp[1] = 8'hB2; loopExp[2] = 8'hA1; loopExp[3] = 8'hB2;
    ssid_ready = 1;
    startRun(1'b1, 1'b1, '0, '0, 6'd2);
    for (int k = 0; k < 4; k++) begin
      check("loopSsid", ssid, loopExp[k]);
      if (k == 3) stop = 1;
      step();
    end
    stop = 0; loop = 0;
    check("loopValid", ssid_valid, 0);
    check("loopDone", done, 1);
    check("loopEmitted", emitted, 4);
    step();

    // Start while busy is ignored; reset at 0x12 clears everything
    startRun(1'b0, 1'b0, 8'h10, 8'h20, 6'd0);
    check("sweepFirst", ssid, 8'h10);
    mode = 1; lin_first = 8'h80; list_len = 6'd3; start = 1;
    step();
    start = 0;
    check("ignoredStart", ssid, 8'h11);
    step();
    check("sweep12", ssid, 8'h12);
    reset = 1; step(); reset = 0;
    check("midRstSsid", ssid, 0);
    check("midRstValid", ssid_valid, 0);
    check("midRstBusy", busy, 0);
    check("midRstDone", done, 0);
    check("midRstEmitted", emitted, 0);
    startRun(1'b1, 1'b0, '0, '0, 6'd2);
    check("replay0", ssid, 8'hA1);
    step();
    check("replay1", ssid, 8'hB2);
    step();
    check("replayDone", done, 1);
    step();

    // Table writes while stalled on index 1
    writeTbl(0, 8'h03); writeTbl(1, 8'h7C); writeTbl(2, 8'h48);
    startRun(1'b1, 1'b0, '0, '0, 6'd3);
    step();
    ssid_ready = 0;
    tbl_wr_en = 1; tbl_wr_addr = 5'd1; tbl_wr_data = 8'h55;
    step();
    check("wrHeldSame", ssid, 8'h7C);
    tbl_wr_addr = 5'd2; tbl_wr_data = 8'h99;
    step();
    tbl_wr_en = 0;
    check("wrHeldNext", ssid, 8'h7C);
    ssid_ready = 1; step();
    check("wrNewValue", ssid, 8'h99);
    step();
    check("wrDone", done, 1);
    step();

    // Randomized traffic
    for (int r = 0; r < 60; r++) begin
      lin_first = SB'($urandom);
      lin_last  = lin_first + SB'($urandom_range(0, 11));
      startRun(1'($urandom), 1'($urandom), lin_first, lin_last, (AW+1)'($urandom_range(0, 40)));
      for (int c = 0; c < 150; c++) begin
        ssid_ready = ($urandom_range(0, 3) != 0);
        stop       = ($urandom_range(0, 49) == 0);
        reset      = ($urandom_range(0, 299) == 0);
        tbl_wr_en  = ($urandom_range(0, 7) == 0);
        tbl_wr_addr = AW'($urandom);
        tbl_wr_data = SB'($urandom);
        start = ($urandom_range(0, 19) == 0);
        if (start) begin
          mode = 1'($urandom); loop = 1'($urandom);
          lin_first = SB'($urandom); lin_last = lin_first + SB'($urandom_range(0, 11));
          list_len = (AW+1)'($urandom_range(0, 40));
        end
        step();
      end
      start = 0; reset = 0; tbl_wr_en = 0; stop = 1;
      step(); step();
      stop = 0;
      step();
      check("randIdle", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
